// File: rtl/vm_pkg.sv
// Shared types for the two-panel vending scheduler.
// No logic here; states, request kinds and credit width only.
// No flow control; consumers decide how the types are used.
package vm_pkg;

    // Width of each panel's credit counter.
    localparam int CW = 3;

    // Dispenser ownership phases.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_VEND,
        ST_CHANGE
    } vm_state_e;

    // Kind of request latched for a panel.
    typedef enum logic {
        REQ_VEND,
        REQ_REFUND
    } vm_req_e;

endpackage

// File: rtl/vm_rr_arb.sv
// Two-way round-robin arbiter choosing which panel gets the dispenser.
// Grant is combinational from req; priority pointer updates on the adv edge.
// No backpressure; the owner pulses adv only when it accepts the grant.
module vm_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    output logic       gnt_vld,
    output logic       gnt
);

    // Panel that wins a tie; starts at panel 0.
    logic prio;

    assign gnt_vld = |req;
    assign gnt     = (req[0] && req[1]) ? prio : req[1];

    // The panel just served loses the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (adv && gnt_vld) begin
            prio <= ~gnt;
        end
    end

endmodule

// File: rtl/vm_sched.sv
// Two-panel credit/vend scheduler sharing one dispenser; optional idle refund via VM_SCHED_TIMEOUT_EN.
// sel->vend is 2 cycles from idle (GRANT, VEND); change follows one unit per cycle.
// Requests arriving while busy are latched; coins to the served or saturated panel are rejected.
module vm_sched
    import vm_pkg::*;
#(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] coin,
    input  logic [1:0] sel,
    input  logic [1:0] cancel,
    output logic       vend,
    output logic       vend_id,
    output logic       chg,
    output logic [1:0] deny,
    output logic [1:0] reject,
    output logic       busy
);

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_CREDIT);

    vm_state_e          state, state_nxt;
    logic [1:0][CW-1:0] credit, credit_nxt;
    logic [1:0]         req_vld, req_vld_nxt;
    vm_req_e            req_typ     [2];
    vm_req_e            req_typ_nxt [2];
    logic               cur;
    logic [CW-1:0]      dec;
    logic               clr_req;
    logic [1:0]         cancel_eff;
    logic [1:0]         req_any;
    logic               arb_vld, arb_gnt, arb_adv;

    assign busy    = (state != ST_IDLE);
    // Same-cycle sel/cancel count so an idle dispenser grants without delay.
    assign req_any = req_vld | sel | cancel_eff;
    assign arb_adv = (state == ST_IDLE) && arb_vld;

    vm_rr_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_any),
        .adv     (arb_adv),
        .gnt_vld (arb_vld),
        .gnt     (arb_gnt)
    );

`ifdef VM_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0][TW-1:0] idle_cnt;
    logic [1:0]         quiet;
    logic [1:0]         tmo;

    // A panel is quiet when it holds credit, sees no activity and is neither pending nor served.
    always_comb begin
        quiet = '0;
        tmo   = '0;
        for (int p = 0; p < 2; p++) begin
            quiet[p] = (credit[p] != '0) && !coin[p] && !sel[p] && !cancel[p] &&
                       !req_vld[p] && !(busy && cur == 1'(p));
            tmo[p]   = quiet[p] && (idle_cnt[p] == TW'(TIMEOUT - 1));
        end
    end

    // Idle counters restart on any activity and after posting a refund.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (!quiet[p] || tmo[p]) begin
                    idle_cnt[p] <= '0;
                end else begin
                    idle_cnt[p] <= idle_cnt[p] + 1'b1;
                end
            end
        end
    end

    // An expired panel behaves exactly like a cancel.
    assign cancel_eff = cancel | tmo;
`else
    assign cancel_eff = cancel;
`endif

    // Dispenser FSM: grant decision, vend pulse, then one change unit per cycle.
    always_comb begin
        state_nxt = state;
        vend      = 1'b0;
        vend_id   = 1'b0;
        chg       = 1'b0;
        deny      = '0;
        dec       = '0;
        clr_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_vld) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                clr_req = 1'b1;
                if (req_typ[cur] == REQ_REFUND) begin
                    state_nxt = (credit[cur] != '0) ? ST_CHANGE : ST_IDLE;
                end else if (credit[cur] >= PRICE_C) begin
                    state_nxt = ST_VEND;
                end else begin
                    deny[cur] = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_VEND: begin
                vend      = 1'b1;
                vend_id   = cur;
                dec       = PRICE_C;
                state_nxt = (credit[cur] != PRICE_C) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                chg       = 1'b1;
                vend_id   = cur;
                dec       = CW'(1);
                state_nxt = (credit[cur] == CW'(1)) ? ST_IDLE : ST_CHANGE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Credit and request bookkeeping; the served panel's credit belongs to the FSM.
    always_comb begin
        credit_nxt  = credit;
        req_vld_nxt = req_vld;
        req_typ_nxt = req_typ;
        reject      = '0;
        for (int p = 0; p < 2; p++) begin
            if (busy && cur == 1'(p)) begin
                reject[p]     = coin[p];
                credit_nxt[p] = credit[p] - dec;
            end else if (coin[p]) begin
                if (credit[p] == MAX_C) begin
                    reject[p] = 1'b1;
                end else begin
                    credit_nxt[p] = credit[p] + 1'b1;
                end
            end
            if (clr_req && cur == 1'(p)) begin
                req_vld_nxt[p] = 1'b0;
            end
            // Refund wins over vend; a repeated request merges with the pending one.
            if (cancel_eff[p]) begin
                req_vld_nxt[p] = 1'b1;
                req_typ_nxt[p] = REQ_REFUND;
            end else if (sel[p] && !req_vld_nxt[p]) begin
                req_vld_nxt[p] = 1'b1;
                req_typ_nxt[p] = REQ_VEND;
            end
        end
    end

    // State, credit, pending requests and the served panel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            credit  <= '0;
            req_vld <= '0;
            req_typ <= '{default: REQ_VEND};
            cur     <= 1'b0;
        end else begin
            state   <= state_nxt;
            credit  <= credit_nxt;
            req_vld <= req_vld_nxt;
            req_typ <= req_typ_nxt;
            if (arb_adv) begin
                cur <= arb_gnt;
            end
        end
    end

endmodule

// File: tb/tb_vm_sched.sv
// Self-checking bench for vm_sched against a transaction-level scheduler model.
// Each cycle's expected outputs come from a per-grant plan of pulses built by the model.
// Directed scenarios first, then randomized coin/sel/cancel traffic.
module tb_vm_sched;

    localparam int PRICE = 3;
    localparam int MAXC  = 4;
    localparam int TMO   = 15;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [1:0] coin   = '0;
    logic [1:0] sel    = '0;
    logic [1:0] cancel = '0;
    logic       vend, vend_id, chg, busy;
    logic [1:0] deny, reject;

    vm_sched #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .coin    (coin),
        .sel     (sel),
        .cancel  (cancel),
        .vend    (vend),
        .vend_id (vend_id),
        .chg     (chg),
        .deny    (deny),
        .reject  (reject),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       vend;
        logic       chg;
        logic [1:0] deny;
    } plan_t;

    int    n_chk = 0;
    int    n_err = 0;
    int    m_credit [2];
    int    m_req    [2];   // 0 none, 1 vend, 2 refund
    int    m_idle   [2];
    int    m_prio;
    int    m_cur;
    plan_t plan [$];
    int    obs_vend = 0;
    int    obs_chg  = 0;
    int    obs_ids  [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_credit[p] = 0;
            m_req[p]    = 0;
            m_idle[p]   = 0;
        end
        m_prio = 0;
        m_cur  = 0;
        plan.delete();
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic [1:0] c, input logic [1:0] s, input logic [1:0] x);
        plan_t      ent;
        logic       e_busy;
        logic [1:0] xe;
        logic [1:0] e_rej;
        int         g, cr;
        @(negedge clk);
        coin = c; sel = s; cancel = x;
        #1;
        e_busy = (plan.size() != 0);
        ent = '0;
        if (e_busy) ent = plan.pop_front();
        xe = x;
        e_rej = '0;
`ifdef VM_SCHED_TIMEOUT_EN
        for (int p = 0; p < 2; p++) begin
            if (m_credit[p] > 0 && !c[p] && !s[p] && !x[p] && m_req[p] == 0 &&
                !(e_busy && m_cur == p)) begin
                if (m_idle[p] == TMO - 1) begin
                    xe[p] = 1'b1;
                    m_idle[p] = 0;
                end else begin
                    m_idle[p]++;
                end
            end else begin
                m_idle[p] = 0;
            end
        end
`endif
        for (int p = 0; p < 2; p++) begin
            if (c[p]) begin
                if ((e_busy && m_cur == p) || m_credit[p] == MAXC) e_rej[p] = 1'b1;
                else m_credit[p]++;
            end
        end
        chk("busy",   32'(busy),   32'(e_busy));
        chk("vend",   32'(vend),   32'(ent.vend));
        chk("chg",    32'(chg),    32'(ent.chg));
        chk("deny",   32'(deny),   32'(ent.deny));
        chk("reject", 32'(reject), 32'(e_rej));
        if (ent.vend || ent.chg) chk("vend_id", 32'(vend_id), 32'(m_cur));
        if (vend === 1'b1) begin
            obs_vend++;
            obs_ids.push_back(int'(vend_id));
        end
        if (chg === 1'b1) obs_chg++;
        for (int p = 0; p < 2; p++) begin
            if (xe[p]) m_req[p] = 2;
            else if (s[p] && m_req[p] == 0) m_req[p] = 1;
        end
        // Idle dispenser: pick a panel and lay out the whole transaction.
        if (!e_busy && (m_req[0] != 0 || m_req[1] != 0)) begin
            if (m_req[0] != 0 && m_req[1] != 0) g = m_prio;
            else g = (m_req[1] != 0) ? 1 : 0;
            m_prio = 1 - g;
            m_cur  = g;
            cr     = m_credit[g];
            if (m_req[g] == 1 && cr < PRICE) begin
                plan.push_back(plan_t'{vend: 1'b0, chg: 1'b0, deny: 2'(1 << g)});
            end else begin
                plan.push_back(plan_t'{vend: 1'b0, chg: 1'b0, deny: 2'b00});
                if (m_req[g] == 1) begin
                    plan.push_back(plan_t'{vend: 1'b1, chg: 1'b0, deny: 2'b00});
                    cr = cr - PRICE;
                end
                for (int k = 0; k < cr; k++)
                    plan.push_back(plan_t'{vend: 1'b0, chg: 1'b1, deny: 2'b00});
                m_credit[g] = 0;
            end
            m_req[g] = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; coin = '0; sel = '0; cancel = '0;
        #1;
        chk("rst_vend",   32'(vend),   32'd0);
        chk("rst_chg",    32'(chg),    32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_deny",   32'(deny),   32'd0);
        chk("rst_reject", 32'(reject), 32'd0);
        chk("rst_id",     32'(vend_id), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        int v0, c0;
        model_reset();
        do_reset();
        idle(2);

        // Exact price on panel 0: vend two cycles after sel, no change.
        v0 = obs_vend; c0 = obs_chg;
        repeat (3) step(2'b01, 2'b00, 2'b00);
        step(2'b00, 2'b01, 2'b00);
        idle(4);
        chk("exact_vend_cnt", 32'(obs_vend - v0), 32'd1);
        chk("exact_chg_cnt",  32'(obs_chg - c0),  32'd0);
        // Credit is now empty, so another sel is denied.
        step(2'b00, 2'b01, 2'b00);
        idle(3);

        // Overpay on panel 1: vend then one change unit.
        v0 = obs_vend; c0 = obs_chg;
        repeat (4) step(2'b10, 2'b00, 2'b00);
        step(2'b00, 2'b10, 2'b00);
        idle(5);
        chk("over_vend_cnt", 32'(obs_vend - v0), 32'd1);
        chk("over_chg_cnt",  32'(obs_chg - c0),  32'd1);
        chk("over_busy_end", 32'(busy), 32'd0);

        // Two simultaneous funded requests, twice: panel 0 leads both times.
        do_reset();
        obs_ids.delete();
        repeat (3) step(2'b11, 2'b00, 2'b00);
        step(2'b00, 2'b11, 2'b00);
        idle(8);
        repeat (3) step(2'b11, 2'b00, 2'b00);
        step(2'b00, 2'b11, 2'b00);
        idle(8);
        chk("tie_vend_cnt", 32'(obs_ids.size()), 32'd4);
        if (obs_ids.size() == 4) begin
            chk("tie1_first",  32'(obs_ids[0]), 32'd0);
            chk("tie1_second", 32'(obs_ids[1]), 32'd1);
            chk("tie2_first",  32'(obs_ids[2]), 32'd0);
        end

        // Underfunded sel is denied and keeps credit; the fifth coin saturates.
        repeat (2) step(2'b01, 2'b00, 2'b00);
        step(2'b00, 2'b01, 2'b00);
        idle(3);
        repeat (3) step(2'b01, 2'b00, 2'b00);
        step(2'b00, 2'b01, 2'b00);
        idle(6);

        // Refund of two units; coins to panel 1 while it is served are refused.
        c0 = obs_chg;
        repeat (2) step(2'b10, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b10);
        step(2'b10, 2'b00, 2'b00);
        step(2'b10, 2'b00, 2'b00);
        idle(4);
        chk("refund_chg_cnt", 32'(obs_chg - c0), 32'd2);

        // Reset in the middle of a change burst drops the rest.
        repeat (4) step(2'b01, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b01);
        step(2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        c0 = obs_chg;
        do_reset();
        idle(6);
        chk("rst_no_more_chg", 32'(obs_chg - c0), 32'd0);
        step(2'b00, 2'b01, 2'b00);
        idle(3);

`ifdef VM_SCHED_TIMEOUT_EN
        // Single coin left alone is handed back after the idle limit.
        do_reset();
        c0 = obs_chg;
        step(2'b01, 2'b00, 2'b00);
        idle(TMO + 6);
        chk("timeout_chg_cnt", 32'(obs_chg - c0), 32'd1);
`endif

        // Randomized traffic on both panels.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] rc, rs, rx;
            for (int p = 0; p < 2; p++) begin
                rc[p] = ($urandom_range(0, 2) == 0);
                rs[p] = ($urandom_range(0, 9) == 0);
                rx[p] = ($urandom_range(0, 29) == 0);
            end
            step(rc, rs, rx);
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vm_sched.md
VM_SCHED -- requirements
Module: vm_sched

Interface
REQ-001 SHALL have parameter PRICE, default 3, meaning credit units needed per vend (1..MAX_CREDIT).
REQ-002 SHALL have parameter MAX_CREDIT, default 4, meaning per-panel credit saturation limit (3-bit credit).
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning idle cycles before auto-refund (used only with VM_SCHED_TIMEOUT_EN).
REQ-004 SHALL have port clk input 1 — single clock, rising edge.
REQ-005 SHALL have port rst_n input 1 — reset, asynchronous assert, active-low.
REQ-006 SHALL have port coin input [1:0] — one-cycle pulse per panel; each pulse adds 1 credit unit.
REQ-007 SHALL have port sel input [1:0] — one-cycle vend-request pulse per panel.
REQ-008 SHALL have port cancel input [1:0] — one-cycle refund-request pulse per panel.
REQ-009 SHALL have port vend output 1 — one-cycle dispense-product pulse.
REQ-010 SHALL have port vend_id output 1 — panel served by current vend or chg pulse.
REQ-011 SHALL have port chg output 1 — one-cycle pulse, one change unit returned.
REQ-012 SHALL have port deny output [1:0] — one-cycle pulse, sel with insufficient credit.
REQ-013 SHALL have port reject output [1:0] — one-cycle pulse, coin refused (saturated, or panel being served).
REQ-014 SHALL have port busy output 1 — high while the shared dispenser is owned.

Function
REQ-015 SHALL keep per-panel credit[p] (3 bit) and latched pending request req[p] (vend or refund type).
REQ-016 SHALL use FSM states IDLE, GRANT, VEND, CHANGE; IDLE->GRANT when any req pending.
REQ-017 SHALL arbitrate round-robin: last-granted panel loses ties; after reset panel 0 has priority.
REQ-018 SHALL, in GRANT, on vend request with credit>=PRICE go VEND; on credit<PRICE pulse deny[p], clear req, return IDLE (credit kept).
REQ-019 SHALL, in VEND, pulse vend for one cycle, subtract PRICE, go CHANGE if remainder>0 else IDLE.
REQ-020 SHALL, in CHANGE, pulse chg each cycle and decrement credit until 0, then IDLE.
REQ-021 SHALL treat refund request in GRANT as direct entry to CHANGE; credit 0 refund returns IDLE without pulses.
REQ-022 SHALL latch sel/cancel arriving while busy; cancel overrides sel for the same panel; duplicates coalesce.
REQ-023 SHALL add coins to the non-served panel while busy; coins to the served panel pulse reject that cycle, no credit change.
REQ-024 SHALL saturate credit at MAX_CREDIT; a coin at saturation pulses reject.
REQ-025 SHALL allow coin and sel in same cycle: credit updates first, arbitration in GRANT sees updated value.
REQ-026 SHALL give latency sel->vend of 2 cycles when IDLE (GRANT, VEND).

Reset
REQ-027 SHALL on rst_n low: state IDLE, credits 0, reqs cleared, RR pointer favours panel 0, all outputs 0.
REQ-028 SHALL on reset mid-VEND/CHANGE abort immediately; undelivered change lost, no further pulses.

Configuration
REQ-029 SHALL, with VM_SCHED_TIMEOUT_EN defined, count idle cycles per panel with credit>0 and no coin/sel/cancel; at TIMEOUT post a refund request.
REQ-030 SHALL, without VM_SCHED_TIMEOUT_EN, hold credit indefinitely; TIMEOUT unused, no counter logic.

Structure
REQ-031 SHALL place FSM state enum, request-type enum and credit width constant in package vm_pkg.
REQ-032 SHALL implement arbitration as sub-module vm_rr_arb (2-way round-robin, req/grant/advance).

Verification
REQ-033 SHALL check: 3 coins panel0, sel0 -> vend=1, vend_id=0 two cycles later, no chg, credit0=0.
REQ-034 SHALL check: 4 coins panel1, sel1 -> vend then one chg pulse, vend_id=1, busy low after.
REQ-035 SHALL check: sel0 and sel1 same cycle both funded -> panel0 vends first, then panel1; next tie favours panel0.
REQ-036 SHALL check: 2 coins panel0, sel0 -> deny[0] pulse, credit stays 2; 5th coin into saturated panel -> reject.
REQ-037 SHALL check: 2 coins panel1, cancel1 -> exactly 2 chg pulses; coin1 during CHANGE -> reject[1].
REQ-038 SHALL check: rst_n low during CHANGE -> all outputs 0 next edge; with VM_SCHED_TIMEOUT_EN, 1 coin idle 15 cycles -> 1 chg.
